intra4x4_mode_decider: RTL and testbench
========================================

# intra4x4_mode_decider

Consumes the eight per-mode 4x4 luma SADs produced by the intra SAD stage and selects the lowest-cost intra 4x4 prediction mode. Each cost is a SAD plus a rate penalty, applied unless the candidate matches the most-probable mode. The block scans the candidates serially, one per clock, under a per-mode availability mask. It returns the winning slot, the H.264 mode number and the cost over a valid/ready handshake to the macroblock mode-decision logic.

## Interface
- SAD_W, 8, width of each input SAD
- PEN_W, 8, width of the rate-penalty input
- COST_W, SAD_W+1, width of the output cost
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; one clock domain only
- in_valid  input  1  SAD set and side info valid
- in_ready  output  1  block can accept a SAD set
- sads[7:0]  input  SAD_W each  slot order 0 V, 1 H, 2 VL, 3 VR, 4 HU, 5 HD, 6 DDL, 7 DDR
- avail  input  8  bit k=1: slot k is a legal candidate
- pred_mode  input  4  most-probable H.264 mode number (0..8)
- penalty  input  PEN_W  cost added to every non-predicted candidate
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- best_slot  output  3  winning slot index
- best_mode  output  4  H.264 mode number of the winning slot
- best_cost  output  COST_W  winning cost
- none_avail  output  1  no candidate was available

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid&&in_ready, capture sads, avail, pred_mode and penalty into registers, clear the running best to cost all-ones with found=0, set idx=0, and go to SCAN.
  - SCAN: in_ready=0. Each cycle, evaluate slot idx and increment idx. After slot 7 is evaluated, go to DONE.
  - DONE: out_valid=1 and all outputs are held stable. When out_valid&&out_ready, go to IDLE.
- Slot to H.264 mode map: V→0, H→1, DDL→3, DDR→4, VR→5, HD→6, VL→7, HU→8. DC (2) is never a candidate.
- Candidate cost = zero-extended sad + (map(idx)==pred_mode ? 0 : penalty), computed at COST_W bits. The sum cannot overflow: 255+255=510.
- Update rule: the candidate replaces the best when avail[idx] && (!found || cost < best_cost). Comparison is strict, so on a tie the lower slot index wins.
- pred_mode=2 or pred_mode>8 matches no slot, so every candidate is penalised.
- All avail bits 0: none_avail=1, best_cost=all-ones (511), best_slot=0, best_mode=0.
- Inputs are sampled only on the accept edge. Changes to the inputs during SCAN or DONE have no effect.

## Timing
- Accept edge E0. Slots 0..7 are evaluated on edges E1..E8. out_valid rises at E8, so latency is 8 clocks from accept to out_valid.
- in_ready is decoded combinationally from state and is high only in IDLE.
- Minimum interval between accepts is 10 clocks: accept at E0, result taken at E9 with out_ready held high, next accept at E10.
- out_ready low holds DONE indefinitely, with outputs unchanged and in_ready=0.
- Reset values, whether asserted at power-up or mid-operation, in any state:
  - State returns to IDLE asynchronously.
  - out_valid=0, best_slot=0, best_mode=0, best_cost=0, none_avail=0.
  - in_ready reads 1 once state is IDLE.
  - Any in-flight SAD set is discarded.

## Structure
- Shared package intra4x4_pkg:
  - slot enum (V, H, VL, VR, HU, HD, DDL, DDR)
  - H.264 mode constants
  - slot→mode lookup function
  - SAD_W and COST_W defaults
- The SAD stage and this block both import the package so the slot order is defined in one place.
- One sub-module, intra4x4_cost_unit: combinational cost = sad + conditional penalty, plus the better-than compare. It is instantiated once inside the SCAN datapath.

## Test plan
- Nominal selection: sads={10,20,30,40,50,60,70,80}, avail=FF, pred_mode=0, penalty=0 → best_slot=0, best_mode=0, best_cost=10, none_avail=0, out_valid exactly 8 clocks after accept.
- Tie-break: all sads=50, avail=FF, pred_mode=2, penalty=4 → best_slot=0, best_cost=54. Then repeat with avail=FE → best_slot=1, best_mode=1.
- Penalty effect: V=30, H=25, others 255, pred_mode=0, penalty=8 → slot 0, cost 30. Then repeat with pred_mode=1 → slot 1, cost 25.
- Mask and mapping: avail=80, sads[7]=200, penalty=255, pred_mode=0 → best_slot=7, best_mode=4, best_cost=455. avail=00 → none_avail=1, best_cost=511.
- Handshake: hold out_ready low for 5 cycles in DONE → outputs stable, in_ready=0, and a new in_valid is ignored. Raise out_ready → return to IDLE, and the next accept occurs no earlier than 10 clocks after the previous one.
- Reset mid-SCAN: assert reset at idx=4 → out_valid=0 and outputs 0 immediately. After release, a fresh set yields the correct result with no leftover state.

Source files
------------

// File: rtl/intra4x4_pkg.sv
// Shared intra 4x4 definitions: slot order, H.264 mode numbers and the slot-to-mode map.
// The SAD stage and the mode decider both import this so the slot order lives in one place.
package intra4x4_pkg;

  localparam int SAD_W_DEF  = 8;
  localparam int PEN_W_DEF  = 8;
  localparam int COST_W_DEF = SAD_W_DEF + 1;

  typedef enum logic [2:0] {
    SLOT_V   = 3'd0,
    SLOT_H   = 3'd1,
    SLOT_VL  = 3'd2,
    SLOT_VR  = 3'd3,
    SLOT_HU  = 3'd4,
    SLOT_HD  = 3'd5,
    SLOT_DDL = 3'd6,
    SLOT_DDR = 3'd7
  } slot_e;

  localparam logic [3:0] MODE_V   = 4'd0;
  localparam logic [3:0] MODE_H   = 4'd1;
  localparam logic [3:0] MODE_DC  = 4'd2;
  localparam logic [3:0] MODE_DDL = 4'd3;
  localparam logic [3:0] MODE_DDR = 4'd4;
  localparam logic [3:0] MODE_VR  = 4'd5;
  localparam logic [3:0] MODE_HD  = 4'd6;
  localparam logic [3:0] MODE_VL  = 4'd7;
  localparam logic [3:0] MODE_HU  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // DC has no slot, so no slot ever maps to MODE_DC.
  function automatic logic [3:0] slot_to_mode(input logic [2:0] slot);
    logic [3:0] mode;
    case (slot_e'(slot))
      SLOT_V:   mode = MODE_V;
      SLOT_H:   mode = MODE_H;
      SLOT_VL:  mode = MODE_VL;
      SLOT_VR:  mode = MODE_VR;
      SLOT_HU:  mode = MODE_HU;
      SLOT_HD:  mode = MODE_HD;
      SLOT_DDL: mode = MODE_DDL;
      default:  mode = MODE_DDR;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/intra4x4_cost_unit.sv
// Combinational candidate cost (SAD plus rate penalty unless it is the most-probable mode)
// and the strict better-than test against the running best.
module intra4x4_cost_unit
  import intra4x4_pkg::*;
#(
  parameter int SAD_W  = SAD_W_DEF,
  parameter int PEN_W  = PEN_W_DEF,
  parameter int COST_W = SAD_W + 1
) (
  input  logic [SAD_W-1:0]  sad,
  input  logic [PEN_W-1:0]  penalty,
  input  logic [3:0]        cand_mode,
  input  logic [3:0]        pred_mode,
  input  logic              cand_avail,
  input  logic              found,
  input  logic [COST_W-1:0] best_cost,
  output logic [COST_W-1:0] cost,
  output logic              better
);

  logic [COST_W-1:0] pen_ext;

  always_comb begin
    pen_ext = (cand_mode == pred_mode) ? '0 : COST_W'(penalty);
    cost    = COST_W'(sad) + pen_ext;
    // Strict compare keeps the earlier (lower) slot on a tie.
    better  = cand_avail && (!found || (cost < best_cost));
  end

endmodule

// File: rtl/intra4x4_mode_decider.sv
// Serial intra 4x4 mode decision: scans the eight slot SADs one per clock and returns
// the lowest-cost available slot, its H.264 mode and cost over a valid/ready handshake.
module intra4x4_mode_decider
  import intra4x4_pkg::*;
#(
  parameter int SAD_W  = SAD_W_DEF,
  parameter int PEN_W  = PEN_W_DEF,
  parameter int COST_W = SAD_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0][SAD_W-1:0] sads,
  input  logic [7:0]            avail,
  input  logic [3:0]            pred_mode,
  input  logic [PEN_W-1:0]      penalty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            best_slot,
  output logic [3:0]            best_mode,
  output logic [COST_W-1:0]     best_cost,
  output logic                  none_avail
);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic              found_q, found_d;
  logic [COST_W-1:0] best_cost_q, best_cost_d;
  logic [2:0]        best_slot_q, best_slot_d;
  logic [3:0]        best_mode_q, best_mode_d;
  logic              none_avail_q, none_avail_d;
  logic              load;

  logic [7:0][SAD_W-1:0] sads_q;
  logic [7:0]            avail_q;
  logic [3:0]            pred_mode_q;
  logic [PEN_W-1:0]      penalty_q;

  logic [COST_W-1:0] cand_cost;
  logic              cand_better;

  intra4x4_cost_unit #(
    .SAD_W  (SAD_W),
    .PEN_W  (PEN_W),
    .COST_W (COST_W)
  ) u_cost (
    .sad        (sads_q[idx_q]),
    .penalty    (penalty_q),
    .cand_mode  (slot_to_mode(idx_q)),
    .pred_mode  (pred_mode_q),
    .cand_avail (avail_q[idx_q]),
    .found      (found_q),
    .best_cost  (best_cost_q),
    .cost       (cand_cost),
    .better     (cand_better)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    found_d      = found_q;
    best_cost_d  = best_cost_q;
    best_slot_d  = best_slot_q;
    best_mode_d  = best_mode_q;
    none_avail_d = none_avail_q;
    load         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load         = 1'b1;
          idx_d        = 3'd0;
          found_d      = 1'b0;
          best_cost_d  = '1;
          best_slot_d  = 3'd0;
          best_mode_d  = 4'd0;
          none_avail_d = 1'b0;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        idx_d = idx_q + 3'd1;
        if (cand_better) begin
          found_d     = 1'b1;
          best_cost_d = cand_cost;
          best_slot_d = idx_q;
          best_mode_d = slot_to_mode(idx_q);
        end
        if (idx_q == 3'd7) begin
          none_avail_d = !(found_q || cand_better);
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      found_q      <= 1'b0;
      best_cost_q  <= '0;
      best_slot_q  <= 3'd0;
      best_mode_q  <= 4'd0;
      none_avail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      found_q      <= found_d;
      best_cost_q  <= best_cost_d;
      best_slot_q  <= best_slot_d;
      best_mode_q  <= best_mode_d;
      none_avail_q <= none_avail_d;
    end
  end

  // Captured SAD set is pure data; it is only ever read while SCAN is active.
  always_ff @(posedge clk) begin
    if (load) begin
      sads_q      <= sads;
      avail_q     <= avail;
      pred_mode_q <= pred_mode;
      penalty_q   <= penalty;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign best_slot  = best_slot_q;
  assign best_mode  = best_mode_q;
  assign best_cost  = best_cost_q;
  assign none_avail = none_avail_q;

endmodule

// File: tb/tb_intra4x4_mode_decider.sv
// Randomized and directed bench for intra4x4_mode_decider against a behavioural model.
module tb_intra4x4_mode_decider;

  typedef int sad_arr_t[8];

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0][7:0] sads = '0;
  logic [7:0]      avail = '0;
  logic [3:0]      pred_mode = '0;
  logic [7:0]      penalty = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2:0]      best_slot;
  logic [3:0]      best_mode;
  logic [8:0]      best_cost;
  logic            none_avail;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_accept = 0;
  int prev_hold   = 0;
  int exp_slot, exp_mode, exp_cost, exp_none;
  bit exp_armed = 1'b0;

  intra4x4_mode_decider dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sads       (sads),
    .avail      (avail),
    .pred_mode  (pred_mode),
    .penalty    (penalty),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .best_slot  (best_slot),
    .best_mode  (best_mode),
    .best_cost  (best_cost),
    .none_avail (none_avail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference: H.264 mode of each slot V,H,VL,VR,HU,HD,DDL,DDR; pick the strictly cheapest.
  function automatic void model(input sad_arr_t s, input int av, input int pr, input int pen,
                                output int slot, output int mode, output int cost,
                                output int none);
    int h264[8] = '{0, 1, 7, 5, 8, 6, 3, 4};
    bit found = 0;
    slot = 0; mode = 0; cost = 511;
    for (int k = 0; k < 8; k++) begin
      int c = s[k] + ((h264[k] == pr) ? 0 : pen);
      if (av[k] && (!found || c < cost)) begin
        found = 1; slot = k; mode = h264[k]; cost = c;
      end
    end
    none = found ? 0 : 1;
  endfunction

  always @(negedge clk) begin
    if (reset && out_valid && exp_armed) begin
      check("best_slot", int'(best_slot), exp_slot);
      check("best_mode", int'(best_mode), exp_mode);
      check("best_cost", int'(best_cost), exp_cost);
      check("none_avail", int'(none_avail), exp_none);
      check("in_ready_in_done", int'(in_ready), 0);
    end
  end

  task automatic scramble_inputs();
    for (int i = 0; i < 8; i++) sads[i] = 8'($urandom);
    avail     = 8'($urandom);
    pred_mode = 4'($urandom);
    penalty   = 8'($urandom);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 30) begin
      @(posedge clk); @(negedge clk); k++;
    end
    if (!in_ready) check("in_ready_wait", 0, 1);
  endtask

  task automatic accept(input sad_arr_t s, input int av, input int pr, input int pen);
    int m_slot, m_mode, m_cost, m_none;
    wait_ready();
    for (int i = 0; i < 8; i++) sads[i] = 8'(s[i]);
    avail     = 8'(av);
    pred_mode = 4'(pr);
    penalty   = 8'(pen);
    in_valid  = 1'b1;
    model(s, av, pr, pen, m_slot, m_mode, m_cost, m_none);
    exp_slot = m_slot; exp_mode = m_mode; exp_cost = m_cost; exp_none = m_none;
    exp_armed = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_txn(input sad_arr_t s, input int av, input int pr, input int pen,
                         input int hold, input bit chk_interval);
    int k;
    out_ready = (hold == 0);
    accept(s, av, pr, pen);
    if (chk_interval) check("accept_interval", cyc - last_accept, 10 + prev_hold);
    last_accept = cyc;
    prev_hold   = hold;
    scramble_inputs();
    k = 0;
    do begin
      @(posedge clk); k++; @(negedge clk);
      if (k == 4) check("in_ready_in_scan", int'(in_ready), 0);
    end while (!out_valid && k < 20);
    check("latency", k, 8);
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) begin
        scramble_inputs();
        @(posedge clk); @(negedge clk);
        check("held_valid", int'(out_valid), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    check("out_valid_after_take", int'(out_valid), 0);
    check("in_ready_after_take", int'(in_ready), 1);
  endtask

  initial begin
    sad_arr_t s;
    int r;

    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_best_cost", int'(best_cost), 0);
    check("rst_best_slot", int'(best_slot), 0);
    check("rst_none_avail", int'(none_avail), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    s = '{10, 20, 30, 40, 50, 60, 70, 80};
    run_txn(s, 8'hFF, 0, 0, 0, 0);
    check("pin_nominal_slot", exp_slot, 0);
    check("pin_nominal_cost", exp_cost, 10);

    s = '{50, 50, 50, 50, 50, 50, 50, 50};
    run_txn(s, 8'hFF, 2, 4, 0, 1);
    check("pin_tie_slot", exp_slot, 0);
    check("pin_tie_cost", exp_cost, 54);
    run_txn(s, 8'hFE, 2, 4, 0, 1);
    check("pin_tie_fe_slot", exp_slot, 1);
    check("pin_tie_fe_mode", exp_mode, 1);

    s = '{30, 25, 255, 255, 255, 255, 255, 255};
    run_txn(s, 8'hFF, 0, 8, 0, 1);
    check("pin_pen0_cost", exp_cost, 30);
    run_txn(s, 8'hFF, 1, 8, 0, 1);
    check("pin_pen1_slot", exp_slot, 1);
    check("pin_pen1_cost", exp_cost, 25);

    for (int i = 0; i < 7; i++) s[i] = $urandom_range(0, 255);
    s[7] = 200;
    run_txn(s, 8'h80, 0, 255, 0, 1);
    check("pin_mask_mode", exp_mode, 4);
    check("pin_mask_cost", exp_cost, 455);
    run_txn(s, 8'h00, 0, 255, 0, 1);
    check("pin_none", exp_none, 1);
    check("pin_none_cost", exp_cost, 511);

    s = '{90, 80, 70, 60, 50, 40, 30, 20};
    run_txn(s, 8'hFF, 5, 3, 5, 1);
    s = '{5, 6, 7, 8, 9, 10, 11, 12};
    run_txn(s, 8'h3C, 7, 1, 0, 1);

    // Reset in the middle of a scan, then a fresh set must be unaffected.
    out_ready = 1'b1;
    s = '{1, 2, 3, 4, 5, 6, 7, 8};
    accept(s, 8'hFF, 0, 0);
    scramble_inputs();
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    exp_armed = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_best_cost", int'(best_cost), 0);
    check("midrst_best_slot", int'(best_slot), 0);
    check("midrst_best_mode", int'(best_mode), 0);
    check("midrst_none", int'(none_avail), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    s = '{100, 90, 80, 15, 70, 60, 50, 40};
    run_txn(s, 8'hF7, 6, 20, 0, 0);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 8; i++)
        s[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(40, 43) : $urandom_range(0, 255);
      r = $urandom_range(0, 7);
      run_txn(s, (r == 0) ? 0 : (r == 1) ? 8'hFF : $urandom_range(0, 255),
              $urandom_range(0, 15), $urandom_range(0, 255),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
